parity_frame_tx: RTL and testbench

- Downstream consumer of the 8-bit XOR parity block (xorpar). Takes a byte plus the parity bit that block produced.
- Serializes the byte as an 11-bit asynchronous frame: start, 8 data bits LSB-first, parity, stop. The line is single-wire and UART-like.
- Recomputes parity internally and flags any disagreement with the upstream parity bit. This gives a live cross-check of the upstream combinational stage.

---
 rtl/parity_frame_tx.sv | 131 +++++++++++++
 tb/tb_parity_frame_tx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_tx.sv
// Serializes a byte as an 11-bit frame: start, 8 data bits LSB-first, parity, stop.
// It also flags when the upstream parity bit disagrees with the even parity of the byte.
module parity_frame_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter bit ODD_PARITY   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       parity_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic       parity_mismatch
);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        par_q, par_d;
    logic        tx_d, rdy_d, busy_d, done_d, mis_d;
    logic        bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            idx_q           <= '0;
            data_q          <= '0;
            par_q           <= 1'b0;
            tx              <= 1'b1;
            in_ready        <= 1'b1;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            parity_mismatch <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            data_q          <= data_d;
            par_q           <= par_d;
            tx              <= tx_d;
            in_ready        <= rdy_d;
            busy            <= busy_d;
            frame_done      <= done_d;
            parity_mismatch <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        par_d   = par_q;
        tx_d    = tx;
        rdy_d   = in_ready;
        busy_d  = busy;
        done_d  = 1'b0;
        mis_d   = 1'b0;

        // Every non-idle state lasts exactly one bit time.
        if (state_q != IDLE)
            cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data_d  = data_in;
                    par_d   = (^data_in) ^ ODD_PARITY;
                    // The cross-check always uses even parity, whatever parity the line carries.
                    mis_d   = (parity_in != (^data_in));
                    tx_d    = 1'b0;
                    rdy_d   = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = 16'd0;
                    idx_d   = 3'd0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d    = data_q[0];
                    idx_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        tx_d    = par_q;
                        state_d = PAR;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = data_q[idx_q + 3'd1];
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    rdy_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                rdy_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: three instances (C=4 even, C=4 odd, C=1 even) checked
// cycle by cycle against a frame model, plus a loopback receiver over all byte values.
module tb_parity_frame_tx;

    logic       clk;
    logic       rst [3];
    logic [7:0] din [3];
    logic       pin [3];
    logic       vin [3];
    logic       rdy [3];
    logic       txo [3];
    logic       bsy [3];
    logic       fd  [3];
    logic       pm  [3];

    int cpb [3] = '{4, 4, 1};
    bit odd [3] = '{1'b0, 1'b1, 1'b0};

    int checks = 0;
    int errors = 0;

    parity_frame_tx #(.CLKS_PER_BIT(4), .ODD_PARITY(1'b0)) u0 (
        .clk(clk), .rst(rst[0]), .data_in(din[0]), .parity_in(pin[0]), .in_valid(vin[0]),
        .in_ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]), .frame_done(fd[0]), .parity_mismatch(pm[0]));
    parity_frame_tx #(.CLKS_PER_BIT(4), .ODD_PARITY(1'b1)) u1 (
        .clk(clk), .rst(rst[1]), .data_in(din[1]), .parity_in(pin[1]), .in_valid(vin[1]),
        .in_ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]), .frame_done(fd[1]), .parity_mismatch(pm[1]));
    parity_frame_tx #(.CLKS_PER_BIT(1), .ODD_PARITY(1'b0)) u2 (
        .clk(clk), .rst(rst[2]), .data_in(din[2]), .parity_in(pin[2]), .in_valid(vin[2]),
        .in_ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]), .frame_done(fd[2]), .parity_mismatch(pm[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         n;
        logic [7:0] d;
        logic       p;
        logic       exp_par;
        logic       exp_mis;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input int n);
        int t = 0;
        @(negedge clk);
        while (rdy[n] !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("u%0d ready_wait", n), 32'(rdy[n]), 32'd1);
    endtask

    // Drives one frame and checks every output on every cycle until the gap after frame_done.
    task automatic run_frame(input int n, input logic [7:0] d, input logic p,
                             input logic ep, input logic em);
        int c = cpb[n];
        logic [10:0] fb;
        fb = {1'b1, ep, d, 1'b0};
        wait_ready(n);
        din[n] = d; pin[n] = p; vin[n] = 1'b1;
        @(posedge clk); #1 vin[n] = 1'b0;
        for (int k = 0; k <= 11 * c; k++) begin
            @(negedge clk);
            chk($sformatf("u%0d d%0h tx k%0d", n, d, k), 32'(txo[n]),
                32'((k < 11 * c) ? fb[k / c] : 1'b1));
            chk($sformatf("u%0d d%0h busy k%0d", n, d, k), 32'(bsy[n]), 32'(k < 11 * c));
            chk($sformatf("u%0d d%0h ready k%0d", n, d, k), 32'(rdy[n]), 32'(k == 11 * c));
            chk($sformatf("u%0d d%0h done k%0d", n, d, k), 32'(fd[n]), 32'(k == 11 * c));
            chk($sformatf("u%0d d%0h mismatch k%0d", n, d, k), 32'(pm[n]),
                32'((k == 0) ? em : 1'b0));
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; din[i] = 8'h00; pin[i] = 1'b0; vin[i] = 1'b0;
        end

        vecs[0] = '{0, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{0, 8'h07, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1, 8'h07, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{0, 8'h03, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{2, 8'h3C, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1, 8'h03, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1, 8'h01, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{2, 8'hFF, 1'b1, 1'b0, 1'b1};

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("idle u%0d tx", i), 32'(txo[i]), 32'd1);
                chk($sformatf("idle u%0d ready", i), 32'(rdy[i]), 32'd1);
                chk($sformatf("idle u%0d busy", i), 32'(bsy[i]), 32'd0);
                chk($sformatf("idle u%0d done", i), 32'(fd[i]), 32'd0);
                chk($sformatf("idle u%0d mismatch", i), 32'(pm[i]), 32'd0);
            end
        end

        foreach (vecs[v])
            run_frame(vecs[v].n, vecs[v].d, vecs[v].p, vecs[v].exp_par, vecs[v].exp_mis);

        // Back-to-back at C=1: in_valid stays high, data changes while busy and must be ignored.
        begin
            logic [10:0] f0, f1;
            f0 = {1'b1, 1'b0, 8'h00, 1'b0};
            f1 = {1'b1, 1'b0, 8'hFF, 1'b0};
            wait_ready(2);
            din[2] = 8'h00; pin[2] = 1'b0; vin[2] = 1'b1;
            @(posedge clk); #1 din[2] = 8'hFF;
            for (int k = 0; k < 24; k++) begin
                @(negedge clk);
                chk($sformatf("b2b tx k%0d", k), 32'(txo[2]),
                    32'((k < 11) ? f0[k] : (k == 11 || k == 23) ? 1'b1 : f1[k - 12]));
                chk($sformatf("b2b done k%0d", k), 32'(fd[2]), 32'(k == 11 || k == 23));
                if (k == 12) vin[2] = 1'b0;
            end
        end

        // Reset in the middle of a C=4 frame
        wait_ready(0);
        din[0] = 8'hA5; pin[0] = 1'b0; vin[0] = 1'b1;
        @(posedge clk); #1 vin[0] = 1'b0;
        repeat (21) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("midrst tx", 32'(txo[0]), 32'd1);
        chk("midrst ready", 32'(rdy[0]), 32'd1);
        chk("midrst busy", 32'(bsy[0]), 32'd0);
        rst[0] = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            chk($sformatf("midrst no_done k%0d", k), 32'(fd[0]), 32'd0);
            chk($sformatf("midrst tx k%0d", k), 32'(txo[0]), 32'd1);
        end

        // Randomized frames against the frame model
        for (int r = 0; r < 30; r++) begin
            int n;
            logic [7:0] d;
            logic p;
            n = int'($urandom_range(0, 2));
            d = 8'($urandom);
            p = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_frame(n, d, p, (^d) ^ odd[n], p != (^d));
        end

        // Exhaustive loopback through a receiver model on the C=1 instance
        for (int v = 0; v < 256; v++) begin
            logic [7:0] rx_d;
            logic       rx_p, rx_s;
            logic [7:0] d;
            d = 8'(v);
            wait_ready(2);
            din[2] = d; pin[2] = ^d; vin[2] = 1'b1;
            @(posedge clk); #1 vin[2] = 1'b0;
            @(negedge clk);
            chk($sformatf("rx start %0h", d), 32'(txo[2]), 32'd0);
            for (int j = 0; j < 8; j++) begin
                repeat (cpb[2]) @(negedge clk);
                rx_d[j] = txo[2];
            end
            repeat (cpb[2]) @(negedge clk);
            rx_p = txo[2];
            repeat (cpb[2]) @(negedge clk);
            rx_s = txo[2];
            chk($sformatf("rx byte %0h", d), 32'(rx_d), 32'(d));
            chk($sformatf("rx parity %0h", d), 32'(rx_p), 32'(^d));
            chk($sformatf("rx stop %0h", d), 32'(rx_s), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
